// File: rtl/icg_enable_ctrl.sv
// Idle-detection clock-gate enable controller with a wake handshake and
// a saturating counter of gated-off cycles.
module icg_enable_ctrl #(
    parameter int IDLE_CYCLES = 8,
    parameter int WAKE_CYCLES = 2,
    parameter int STAT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              act,
    input  logic              wake_req,
    input  logic              test_en,
    input  logic              clr_stats,
    output logic              wake_ack,
    output logic              gate_en,
    output logic [1:0]        state,
    output logic [STAT_W-1:0] gated_cycles
);

    typedef enum logic [1:0] {
        ST_ON   = 2'd0,
        ST_HOLD = 2'd1,
        ST_OFF  = 2'd2,
        ST_WAKE = 2'd3
    } state_t;

    localparam logic [7:0]        IDLE_M1  = 8'(IDLE_CYCLES - 1);
    localparam logic [7:0]        WAKE_M1  = 8'(WAKE_CYCLES - 1);
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    state_t            state_q;
    logic [7:0]        cnt_q;
    logic              gate_en_q;
    logic [STAT_W-1:0] gated_q;
    logic              busy;

    assign busy = act | wake_req;

    // The counter is shared: idle run length in HOLD, settle time in WAKE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ON;
            cnt_q     <= 8'd0;
            gate_en_q <= 1'b1;
        end else if (test_en) begin
            state_q   <= ST_ON;
            cnt_q     <= 8'd0;
            gate_en_q <= 1'b1;
        end else begin
            case (state_q)
                ST_ON: begin
                    if (!busy) begin
                        if (IDLE_CYCLES == 1) begin
                            state_q   <= ST_OFF;
                            gate_en_q <= 1'b0;
                        end else begin
                            state_q <= ST_HOLD;
                            cnt_q   <= 8'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (busy) begin
                        state_q <= ST_ON;
                        cnt_q   <= 8'd0;
                    end else if (cnt_q == IDLE_M1) begin
                        state_q   <= ST_OFF;
                        gate_en_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_OFF: begin
                    if (busy) begin
                        state_q   <= ST_WAKE;
                        cnt_q     <= 8'd0;
                        gate_en_q <= 1'b1;
                    end
                end
                ST_WAKE: begin
                    if (cnt_q == WAKE_M1) begin
                        state_q <= ST_ON;
                        cnt_q   <= 8'd0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q   <= ST_ON;
                    cnt_q     <= 8'd0;
                    gate_en_q <= 1'b1;
                end
            endcase
        end
    end

    // Clear takes priority over a same-edge increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gated_q <= '0;
        end else if (clr_stats) begin
            gated_q <= '0;
        end else if (state_q == ST_OFF && !test_en && gated_q != STAT_MAX) begin
            gated_q <= gated_q + 1'b1;
        end
    end

    assign gate_en      = gate_en_q | test_en;
    assign wake_ack     = wake_req & (state_q == ST_ON || state_q == ST_HOLD);
    assign state        = state_q;
    assign gated_cycles = gated_q;

endmodule
